// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter: loads a clamped BCD preset, decrements once per
// prescaled tick while running, and pulses Done for one cycle on reaching zero.
module bcd_countdown_timer #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                  Clk,
    input  logic                  R,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadVal,
    input  logic                  Start,
    input  logic                  Stop,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  Running,
    output logic                  Done
);

    localparam int unsigned QW = 4 * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [QW-1:0]   q_dec;
    logic [QW-1:0]   load_clamped;
    logic            dec_borrow;
    logic [3:0]      dec_digit;
    logic [3:0]      load_digit;
    logic            q_nonzero;

    assign q_nonzero = |Q;

    // Ripple-borrow BCD decrement; a zero count stays at zero.
    always_comb begin
        q_dec      = Q;
        dec_borrow = 1'b1;
        dec_digit  = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dec_digit = Q[4*i +: 4];
            if (dec_borrow) begin
                if (dec_digit == 4'd0) begin
                    q_dec[4*i +: 4] = 4'd9;
                end else begin
                    q_dec[4*i +: 4] = dec_digit - 4'd1;
                    dec_borrow      = 1'b0;
                end
            end
        end
        if (dec_borrow) begin
            q_dec = '0;
        end
    end

    // Non-decimal preset digits saturate at 9.
    always_comb begin
        load_clamped = '0;
        load_digit   = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_digit = LoadVal[4*i +: 4];
            load_clamped[4*i +: 4] = (load_digit > 4'd9) ? 4'd9 : load_digit;
        end
    end

    // Control FSM with registered Q/Running/Done; priority R > Load > Stop > Start.
    always_ff @(posedge Clk) begin
        if (R) begin
            state   <= IDLE;
            presc   <= '0;
            Q       <= '0;
            Running <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Load) begin
                Q       <= load_clamped;
                presc   <= '0;
                state   <= IDLE;
                Running <= 1'b0;
            end else begin
                case (state)
                    IDLE, PAUSED: begin
                        if (!Stop && Start && q_nonzero) begin
                            state   <= RUN;
                            Running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (Stop) begin
                            state   <= PAUSED;
                            Running <= 1'b0;
                        end else if (presc == PRESC_MAX) begin
                            presc <= '0;
                            Q     <= q_dec;
                            if (q_dec == '0) begin
                                state   <= DONE;
                                Running <= 1'b0;
                                Done    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    DONE: begin
                        Q <= '0;
                    end
                    default: begin
                        state   <= IDLE;
                        Running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer (DIGITS=2, TICK_DIV=4): a vector table
// for reset/clamp/borrow/expiry plus hand sequences for pause, reload and reset.
module tb_bcd_countdown_timer;

    logic       Clk = 1'b0;
    logic       R = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] LoadVal = 8'h00;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic [7:0] Q;
    logic       Running;
    logic       Done;

    int n_vec = 0;
    int n_err = 0;

    bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(4)) dut (
        .Clk     (Clk),
        .R       (R),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Start   (Start),
        .Stop    (Stop),
        .Q       (Q),
        .Running (Running),
        .Done    (Done)
    );

    always #5 Clk = ~Clk;

    // Inputs held for cnt cycles; outputs checked after the last edge.
    typedef struct {
        string      name;
        int         cnt;
        logic       r;
        logic       ld;
        logic [7:0] lv;
        logic       st;
        logic       sp;
        logic [7:0] q;
        logic       run;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, int cnt, logic r, logic ld, logic [7:0] lv,
                                logic st, logic sp, logic [7:0] q, logic run, logic done);
        vec_t v;
        v.name = name; v.cnt = cnt; v.r = r; v.ld = ld; v.lv = lv;
        v.st = st; v.sp = sp; v.q = q; v.run = run; v.done = done;
        return v;
    endfunction

    task automatic drive(logic r, logic ld, logic [7:0] lv, logic st, logic sp);
        R = r; Load = ld; LoadVal = lv; Start = st; Stop = sp;
    endtask

    task automatic step(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check(string name, logic [7:0] q, logic run, logic done);
        n_vec++;
        if (Q !== q || Running !== run || Done !== done) begin
            n_err++;
            $display("FAIL %s: got Q=%h Running=%b Done=%b, want Q=%h Running=%b Done=%b",
                     name, Q, Running, Done, q, run, done);
        end
    endtask

    // Apply inputs for n cycles then check.
    task automatic apply(string name, int n, logic r, logic ld, logic [7:0] lv,
                         logic st, logic sp, logic [7:0] q, logic run, logic done);
        drive(r, ld, lv, st, sp);
        step(n);
        check(name, q, run, done);
    endtask

    initial begin
        //                name            cnt r  ld lv     st sp  q      run done
        vecs.push_back(mk("reset1",        1, 1, 1, 8'h55, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk("reset2",        1, 1, 1, 8'h55, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk("clamp_af",      1, 0, 1, 8'hAF, 0, 0, 8'h99, 0, 0));
        vecs.push_back(mk("clamp_c7",      1, 0, 1, 8'hC7, 0, 0, 8'h97, 0, 0));
        vecs.push_back(mk("load_12",       1, 0, 1, 8'h12, 0, 0, 8'h12, 0, 0));
        vecs.push_back(mk("start_12",      1, 0, 0, 8'h00, 1, 0, 8'h12, 1, 0));
        vecs.push_back(mk("hold_12",       3, 0, 0, 8'h00, 0, 0, 8'h12, 1, 0));
        vecs.push_back(mk("dec_11",        1, 0, 0, 8'h00, 0, 0, 8'h11, 1, 0));
        vecs.push_back(mk("hold_11",       3, 0, 0, 8'h00, 1, 0, 8'h11, 1, 0));
        vecs.push_back(mk("dec_10",        1, 0, 0, 8'h00, 0, 0, 8'h10, 1, 0));
        vecs.push_back(mk("hold_10",       3, 0, 0, 8'h00, 0, 0, 8'h10, 1, 0));
        vecs.push_back(mk("borrow_09",     1, 0, 0, 8'h00, 0, 0, 8'h09, 1, 0));
        vecs.push_back(mk("hold_09",       3, 0, 0, 8'h00, 0, 0, 8'h09, 1, 0));
        vecs.push_back(mk("dec_08",        1, 0, 0, 8'h00, 0, 0, 8'h08, 1, 0));
        vecs.push_back(mk("load_02",       1, 0, 1, 8'h02, 0, 0, 8'h02, 0, 0));
        vecs.push_back(mk("start_02",      1, 0, 0, 8'h00, 1, 0, 8'h02, 1, 0));
        vecs.push_back(mk("hold_02",       3, 0, 0, 8'h00, 0, 0, 8'h02, 1, 0));
        vecs.push_back(mk("dec_01",        1, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0));
        vecs.push_back(mk("hold_01",       3, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0));
        vecs.push_back(mk("expire",        1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk("done_pulse",    1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk("start_in_done", 4, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk("load_00",       1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk("start_at_0",    4, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].name, vecs[i].cnt, vecs[i].r, vecs[i].ld, vecs[i].lv,
                  vecs[i].st, vecs[i].sp, vecs[i].q, vecs[i].run, vecs[i].done);
        end

        // Pause/resume: Stop sampled with prescaler at 2, so resume needs two ticks.
        apply("p_load_05",   1, 0, 1, 8'h05, 0, 0, 8'h05, 1'b0, 0);
        apply("p_start",     1, 0, 0, 8'h00, 1, 0, 8'h05, 1'b1, 0);
        apply("p_dec_04",    4, 0, 0, 8'h00, 0, 0, 8'h04, 1'b1, 0);
        apply("p_run_04",    2, 0, 0, 8'h00, 0, 0, 8'h04, 1'b1, 0);
        apply("p_stop",      1, 0, 0, 8'h00, 0, 1, 8'h04, 1'b0, 0);
        for (int k = 0; k < 20; k++) begin
            apply("p_frozen", 1, 0, 0, 8'h00, 0, 0, 8'h04, 1'b0, 0);
        end
        apply("p_resume",    1, 0, 0, 8'h00, 1, 0, 8'h04, 1'b1, 0);
        apply("p_resume_1",  1, 0, 0, 8'h00, 0, 0, 8'h04, 1'b1, 0);
        apply("p_dec_03",    1, 0, 0, 8'h00, 0, 0, 8'h03, 1'b1, 0);
        apply("p_startstop", 1, 0, 0, 8'h00, 1, 1, 8'h03, 1'b0, 0);
        apply("p_ss_paused", 3, 0, 0, 8'h00, 1, 1, 8'h03, 1'b0, 0);

        // Load during RUN returns to IDLE and clears the prescaler.
        apply("l_start",     1, 0, 0, 8'h00, 1, 0, 8'h03, 1'b1, 0);
        apply("l_run",       1, 0, 0, 8'h00, 0, 0, 8'h03, 1'b1, 0);
        apply("l_load_30",   1, 0, 1, 8'h30, 1, 0, 8'h30, 1'b0, 0);
        apply("l_idle_30",   2, 0, 0, 8'h00, 0, 0, 8'h30, 1'b0, 0);
        apply("l_start_30",  1, 0, 0, 8'h00, 1, 0, 8'h30, 1'b1, 0);
        apply("l_hold_30",   3, 0, 0, 8'h00, 0, 0, 8'h30, 1'b1, 0);
        apply("l_borrow_29", 1, 0, 0, 8'h00, 0, 0, 8'h29, 1'b1, 0);

        // Mid-run reset overrides Load and Start.
        apply("r_load_47",   1, 0, 1, 8'h47, 0, 0, 8'h47, 1'b0, 0);
        apply("r_start",     1, 0, 0, 8'h00, 1, 0, 8'h47, 1'b1, 0);
        apply("r_run",       2, 0, 0, 8'h00, 0, 0, 8'h47, 1'b1, 0);
        apply("r_reset",     1, 1, 1, 8'h88, 1, 0, 8'h00, 1'b0, 0);
        apply("r_after",     2, 0, 0, 8'h00, 1, 0, 8'h00, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Multi-digit BCD down-counter timer: loads a BCD preset, decrements once per prescaled tick, and flags expiry. It is the counterpart of the team's free-running up-counters in the counters lab. Those count up from 0 and wrap. This block counts down from a loaded value and stops at 0. Q feeds the existing per-digit seven-segment decoders; Done drives LED or buzzer logic.

Parameters:
DIGITS, 2, number of BCD digits (Q width = 4*DIGITS)
TICK_DIV, 50000000, Clk cycles per decrement (>=1; benches use 4)

Ports:
Clk  input  1  system clock, all logic on posedge
R  input  1  synchronous active-high reset
Load  input  1  load LoadVal into Q (pulse or level)
LoadVal  input  4*DIGITS  BCD preset, digit 0 in bits [3:0]
Start  input  1  start or resume countdown (sampled each cycle)
Stop  input  1  pause countdown
Q  output  4*DIGITS  current BCD count (registered)
Running  output  1  high while state RUN
Done  output  1  one-cycle pulse when count reaches 0

Behaviour:
- One clock (Clk). Reset R is synchronous and active-high. All outputs are registered.
- Reset: Q=0, Running=0, Done=0, prescaler=0, state=IDLE. R overrides every other input, including mid-run.
- States: IDLE, RUN, PAUSED, DONE. Running = (state==RUN).
- Input priority each cycle: R > Load > Stop > Start.
- Load (any state):
  - Q <= LoadVal; any digit >9 is clamped to 9.
  - Prescaler <= 0; state -> IDLE.
  - Done is not asserted that cycle.
- Start in IDLE or PAUSED:
  - If Q != 0, state -> RUN.
  - If Q == 0, no state change and no Done.
  - Start in RUN or DONE is ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - On the cycle the prescaler == TICK_DIV-1: prescaler <= 0 and Q is BCD-decremented.
  - First decrement is visible on Q exactly TICK_DIV cycles after the edge that sampled Start.
- BCD decrement:
  - Digit 0 decrements by 1.
  - A digit at 0 becomes 9 and borrows from the next digit; ripple is combinational within the cycle.
  - Q never decrements below 0.
- Expiry:
  - When the decrement yields Q==0: state -> DONE, Running <= 0, Done <= 1 for exactly one cycle.
  - Done is coincident with the first cycle Q reads 0.
- Stop in RUN: state -> PAUSED; prescaler and Q frozen. Start from PAUSED resumes with the retained prescaler value.
- Start and Stop in the same cycle: Stop wins (RUN -> PAUSED; IDLE/PAUSED stay put).
- DONE: Q held at 0; Start and Stop ignored. Only Load or R leaves DONE.
- TICK_DIV=1: Q decrements every cycle while in RUN.

Test Plan:
- Reset: R high 2 cycles with Load=1 -> Q=8'h00, Running=0, Done=0 on the first edge; Load ignored.
- Borrow: TICK_DIV=4, Load 8'h12, then Start -> Q steps 12,11,10,09,08 every 4 cycles. First change is 4 cycles after Start; 10->09 borrow is correct.
- Expiry: Load 8'h02, Start -> Q=01 at +4 and Q=00 at +8. Done is high only at +8; Running falls the same cycle. A later Start leaves Q=00 and Done=0.
- Pause/resume: Load 8'h05, Start, Stop at +6 -> Q=04, frozen for 20 cycles. Start -> Q=03 two cycles later (prescaler retained). Start+Stop together while RUN -> PAUSED.
- Clamp and Load priority: Load 8'hAF -> Q=8'h99. Load 8'h30 during RUN -> IDLE, Q=30, prescaler cleared. Load 8'h00 then Start -> stays IDLE, Done=0.
- Mid-run reset: R asserted while RUN with Q=8'h47 -> next edge Q=00, Running=0, Done=0.
